// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, resolution helpers and FSM/control types
// for the vga_timing_scaler engine.
package vga_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } vga_state_t;

  // Sync/blank bundle carried down the latency pipe alongside the colour.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  function automatic int res_scale(input logic [55:0] res);
    if (res == "160x120") return 4;
    if (res == "320x240") return 2;
    return 1;
  endfunction

  function automatic int res_x_w(input logic [55:0] res);
    if (res == "160x120") return 8;
    if (res == "320x240") return 9;
    return 10;
  endfunction

  function automatic int res_y_w(input logic [55:0] res);
    if (res == "160x120") return 8;
    if (res == "320x240") return 8;
    return 9;
  endfunction

  // {R,G,B} on/off for the 80-pixel-wide colour bars.
  function automatic logic [2:0] bar_rgb(input logic [9:0] h);
    if (h < 10'd80)  return 3'b111;
    if (h < 10'd160) return 3'b110;
    if (h < 10'd240) return 3'b011;
    if (h < 10'd320) return 3'b010;
    if (h < 10'd400) return 3'b101;
    if (h < 10'd480) return 3'b100;
    if (h < 10'd560) return 3'b001;
    return 3'b000;
  endfunction

endpackage

// File: rtl/vga_timing_scaler_if.sv
// Pixel-source side of the VGA engine: logical coordinates out, colour back in.
interface vga_timing_scaler_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int CW  = 8
);
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic           coord_valid;
  logic           frame_start;
  logic [CW-1:0]  r_in;
  logic [CW-1:0]  g_in;
  logic [CW-1:0]  b_in;

  modport master (
    output x_out, y_out, coord_valid, frame_start,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x_out, y_out, coord_valid, frame_start,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/vga_chan_expand.sv
// Widens a W-bit colour channel to 8 bits by repeating it MSB-first.
module vga_chan_expand #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_chan,
  output logic [7:0]   o_chan
);
  for (genvar i = 0; i < 8; i++) begin : g_rep
    assign o_chan[7-i] = i_chan[W-1-(i%W)];
  end
endmodule

// File: rtl/vga_timing_scaler.sv
// 640x480@60 VGA engine with 1x/2x/4x logical coordinates and latency-aligned DAC outputs.
// Define VGA_TEST_PATTERN_EN to build an internal 8-bar colour pattern selected by test_mode.
module vga_timing_scaler
  import vga_pkg::*;
#(
  parameter logic [55:0] RESOLUTION    = "640x480",
  parameter int          CHANNEL_SIZES = 8,
  parameter int          PIPE_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_lock,
  input  logic                test_mode,
  vga_timing_scaler_if.master pix,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                VGA_CLK
);
  // state     | meaning
  // WAIT_LOCK | counters held at 0, outputs blanked, waiting for pll_lock
  // RUN       | h/v counters advance every pixel clock

  localparam int SHIFT = $clog2(res_scale(RESOLUTION));
  localparam int X_W   = res_x_w(RESOLUTION);
  localparam int Y_W   = res_y_w(RESOLUTION);

  vga_state_t     r_state;
  logic [9:0]     r_h;
  logic [9:0]     r_v;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_cv;
  logic           r_fs;
  vga_ctl_t       r_ctl_pipe [0:PIPE_LATENCY];
  logic [7:0]     r_vga_r;
  logic [7:0]     r_vga_g;
  logic [7:0]     r_vga_b;
  logic           r_vga_hs;
  logic           r_vga_vs;
  logic           r_vga_blank_n;

  logic [9:0]     w_h_nxt;
  logic [9:0]     w_v_nxt;
  logic           w_vis_nxt;
  vga_ctl_t       w_ctl_nxt;
  vga_ctl_t       w_ctl_tap;
  logic [7:0]     w_r_exp;
  logic [7:0]     w_g_exp;
  logic [7:0]     w_b_exp;
  logic [7:0]     w_r8;
  logic [7:0]     w_g8;
  logic [7:0]     w_b8;

  // Coordinate registers are loaded from the next counter value so they line up with r_h/r_v.
  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (r_state == RUN) begin
      if (r_h == H_TOTAL - 10'd1) begin
        w_v_nxt = (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_nxt = r_h + 10'd1;
        w_v_nxt = r_v;
      end
    end
    w_vis_nxt         = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    w_ctl_nxt         = CTL_IDLE;
    w_ctl_nxt.hs      = !((w_h_nxt >= H_SYNC_START) && (w_h_nxt < H_SYNC_END));
    w_ctl_nxt.vs      = !((w_v_nxt >= V_SYNC_START) && (w_v_nxt < V_SYNC_END));
    w_ctl_nxt.blank_n = w_vis_nxt;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] r_bar_pipe [0:PIPE_LATENCY];
  logic [2:0] w_bar_tap;
`endif

  always_ff @(posedge clk) begin
    if (rst || !pll_lock) begin
      r_state <= WAIT_LOCK;
      r_h     <= '0;
      r_v     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cv    <= 1'b0;
      r_fs    <= 1'b0;
      for (int k = 0; k <= PIPE_LATENCY; k++) begin
        r_ctl_pipe[k] <= CTL_IDLE;
      end
`ifdef VGA_TEST_PATTERN_EN
      for (int k = 0; k <= PIPE_LATENCY; k++) begin
        r_bar_pipe[k] <= 3'b000;
      end
`endif
    end else begin
      r_state       <= RUN;
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_cv          <= w_vis_nxt;
      r_x           <= w_vis_nxt ? X_W'(w_h_nxt >> SHIFT) : '0;
      r_y           <= w_vis_nxt ? Y_W'(w_v_nxt >> SHIFT) : '0;
      r_fs          <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
      r_ctl_pipe[0] <= w_ctl_nxt;
      for (int k = 1; k <= PIPE_LATENCY; k++) begin
        r_ctl_pipe[k] <= r_ctl_pipe[k-1];
      end
`ifdef VGA_TEST_PATTERN_EN
      r_bar_pipe[0] <= bar_rgb(w_h_nxt);
      for (int k = 1; k <= PIPE_LATENCY; k++) begin
        r_bar_pipe[k] <= r_bar_pipe[k-1];
      end
`endif
    end
  end

  assign w_ctl_tap = r_ctl_pipe[PIPE_LATENCY];

  vga_chan_expand #(.W(CHANNEL_SIZES)) u_exp_r (.i_chan(pix.r_in), .o_chan(w_r_exp));
  vga_chan_expand #(.W(CHANNEL_SIZES)) u_exp_g (.i_chan(pix.g_in), .o_chan(w_g_exp));
  vga_chan_expand #(.W(CHANNEL_SIZES)) u_exp_b (.i_chan(pix.b_in), .o_chan(w_b_exp));

`ifdef VGA_TEST_PATTERN_EN
  assign w_bar_tap = r_bar_pipe[PIPE_LATENCY];
  assign w_r8      = test_mode ? {8{w_bar_tap[2]}} : w_r_exp;
  assign w_g8      = test_mode ? {8{w_bar_tap[1]}} : w_g_exp;
  assign w_b8      = test_mode ? {8{w_bar_tap[0]}} : w_b_exp;
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_r8 = w_r_exp;
  assign w_g8 = w_g_exp;
  assign w_b8 = w_b_exp;
`endif

  always_ff @(posedge clk) begin
    if (rst || !pll_lock) begin
      r_vga_r       <= 8'h00;
      r_vga_g       <= 8'h00;
      r_vga_b       <= 8'h00;
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_vga_blank_n <= 1'b0;
    end else begin
      r_vga_r       <= w_ctl_tap.blank_n ? w_r8 : 8'h00;
      r_vga_g       <= w_ctl_tap.blank_n ? w_g8 : 8'h00;
      r_vga_b       <= w_ctl_tap.blank_n ? w_b8 : 8'h00;
      r_vga_hs      <= w_ctl_tap.hs;
      r_vga_vs      <= w_ctl_tap.vs;
      r_vga_blank_n <= w_ctl_tap.blank_n;
    end
  end

  assign pix.x_out       = r_x;
  assign pix.y_out       = r_y;
  assign pix.coord_valid = r_cv;
  assign pix.frame_start = r_fs;

  assign VGA_R       = r_vga_r;
  assign VGA_G       = r_vga_g;
  assign VGA_B       = r_vga_b;
  assign VGA_HS      = r_vga_hs;
  assign VGA_VS      = r_vga_vs;
  assign VGA_BLANK_N = r_vga_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = ~clk;

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Directed bench for vga_timing_scaler: a 160x120/4-bit/latency-2 instance and a 640x480/5-bit/latency-0 instance.
module tb_vga_timing_scaler;
  logic clk;
  logic rst;
  logic pll_lock;
  logic test_mode;

  vga_timing_scaler_if #(.X_W(8),  .Y_W(8), .CW(4)) pix1 ();
  vga_timing_scaler_if #(.X_W(10), .Y_W(9), .CW(5)) pix0 ();

  logic [7:0] r1, g1, b1, r0, g0, b0;
  logic       hs1, vs1, bl1, sn1, vc1;
  logic       hs0, vs0, bl0, sn0, vc0;

  int n_cmp;
  int n_bad;
  int cur_n;
  int hs_low;
  int fs_seen;

  vga_timing_scaler #(.RESOLUTION("160x120"), .CHANNEL_SIZES(4), .PIPE_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .test_mode(test_mode), .pix(pix1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
    .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1), .VGA_CLK(vc1)
  );

  vga_timing_scaler #(.RESOLUTION("640x480"), .CHANNEL_SIZES(5), .PIPE_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .test_mode(test_mode), .pix(pix0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0),
    .VGA_BLANK_N(bl0), .VGA_SYNC_N(sn0), .VGA_CLK(vc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timing model; n counts cycles from the first RUN cycle, negative means idle.
  function automatic int hh(input int n);
    return n % 800;
  endfunction
  function automatic int vv(input int n);
    return (n / 800) % 525;
  endfunction
  function automatic bit vis(input int n);
    return (n >= 0) && (hh(n) < 640) && (vv(n) < 480);
  endfunction
  function automatic bit hs_n(input int n);
    return !((n >= 0) && (hh(n) >= 656) && (hh(n) < 752));
  endfunction
  function automatic bit vs_n(input int n);
    return !((n >= 0) && (vv(n) >= 490) && (vv(n) < 492));
  endfunction
  function automatic int xc(input int n, input int sh);
    return vis(n) ? (hh(n) >> sh) : 0;
  endfunction
  function automatic int yc(input int n, input int sh);
    return vis(n) ? (vv(n) >> sh) : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (n=%0d)", tag, got, exp, cur_n);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source with a two-cycle read latency; off-screen coordinates return full-scale to probe blanking.
  task automatic drive(input int n);
    pix1.r_in = vis(n - 2) ? 4'(xc(n - 2, 2)) : 4'hF;
  endtask

  task automatic check_cycle(input int n);
    int         m1;
    int         m0;
    bit         v1;
    bit         v0;
    logic [3:0] xr;
    m1 = n - 3;
    m0 = n - 1;
    v1 = vis(m1);
    v0 = vis(m0);
    xr = 4'(xc(m1, 2));
    cur_n = n;
    if (n == 0) hs_low = 0;
    if (n >= 0 && n < 1600 && hs1 == 1'b0) hs_low++;
    if (pix1.frame_start === 1'b1) fs_seen++;
    if (!(n < 4000 || n >= 99 * 800)) return;

    check_val("x1",  32'(pix1.x_out),       32'(xc(n, 2)));
    check_val("y1",  32'(pix1.y_out),       32'(yc(n, 2)));
    check_val("cv1", 32'(pix1.coord_valid), 32'(vis(n)));
    check_val("fs1", 32'(pix1.frame_start), 32'(n == 0));
    check_val("hs1", 32'(hs1),              32'(hs_n(m1)));
    check_val("vs1", 32'(vs1),              32'(vs_n(m1)));
    check_val("bl1", 32'(bl1),              32'(v1));
    check_val("r1",  32'(r1),               v1 ? 32'({xr, xr}) : 32'd0);
    check_val("g1",  32'(g1),               v1 ? 32'h55 : 32'd0);
    check_val("b1",  32'(b1),               v1 ? 32'h99 : 32'd0);

    check_val("x0",  32'(pix0.x_out),       32'(xc(n, 0)));
    check_val("y0",  32'(pix0.y_out),       32'(yc(n, 0)));
    check_val("cv0", 32'(pix0.coord_valid), 32'(vis(n)));
    check_val("fs0", 32'(pix0.frame_start), 32'(n == 0));
    check_val("hs0", 32'(hs0),              32'(hs_n(m0)));
    check_val("vs0", 32'(vs0),              32'(vs_n(m0)));
    check_val("bl0", 32'(bl0),              32'(v0));
    check_val("r0",  32'(r0),               v0 ? 32'hB5 : 32'd0);
    check_val("g0",  32'(g0),               v0 ? 32'h08 : 32'd0);
    check_val("b0",  32'(b0),               v0 ? 32'hFF : 32'd0);

    case (n)
      1:    check_val("r0_expand_10110", 32'(r0), 32'hB5);
      2:    check_val("bl1_before_first", 32'(bl1), 32'd0);
      3:    begin
              check_val("bl1_first_rise", 32'(bl1), 32'd1);
              check_val("r1_first_x0",    32'(r1),  32'd0);
            end
      4:    check_val("x1_h4", 32'(pix1.x_out), 32'd1);
      43:   check_val("r1_x10_AA", 32'(r1), 32'hAA);
      639:  check_val("x1_h639", 32'(pix1.x_out), 32'd159);
      643:  check_val("r1_blank_F", 32'(r1), 32'd0);
      658:  check_val("hs1_before_sync", 32'(hs1), 32'd1);
      659:  check_val("hs1_sync_start", 32'(hs1), 32'd0);
      2410: check_val("y1_line3", 32'(pix1.y_out), 32'd0);
      3200: check_val("y1_line4", 32'(pix1.y_out), 32'd1);
      1600: check_val("hs1_low_2lines", 32'(hs_low), 32'd192);
      default: ;
    endcase
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    cur_n        = -100;
    hs_low       = 0;
    fs_seen      = 0;
    rst          = 1'b1;
    pll_lock     = 1'b1;
    test_mode    = 1'b0;
    pix1.g_in    = 4'h5;
    pix1.b_in    = 4'h9;
    pix0.r_in    = 5'b10110;
    pix0.g_in    = 5'b00001;
    pix0.b_in    = 5'b11111;
    drive(-100);

    repeat (4) begin
      tick();
      check_cycle(-100);
      check_val("sync_n1", 32'(sn1), 32'd0);
      check_val("vga_clk1", 32'(vc1), 32'd1);
    end
    rst = 1'b0;

    for (int n = 0; n <= 80300; n++) begin
      tick();
      check_cycle(n);
      if (n == 80300) pll_lock = 1'b0;
      drive(n);
    end

    for (int k = 0; k < 6; k++) begin
      tick();
      check_cycle(-100);
      drive(-100);
    end
    pll_lock = 1'b1;

    for (int n = 0; n < 1700; n++) begin
      tick();
      check_cycle(n);
      drive(n);
    end

    check_val("frame_start_count", 32'(fs_seen), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
